// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Handshake and data bundle between the upstream decoder, the issue stage
//   and the ALU/EX consumer.
//   Upstream side : FLUSH, IN_VALID/IN_READY, IN_A, IN_B, ALUOP, FUNCT3, FUNCT7
//   Consumer side : OUT_VALID/OUT_READY, A, B, OPERATION, ILLEGAL
//   Status        : ISSUE_CNT (saturating pop counter)
//   master = producer/consumer environment, slave = the issue stage.
interface alu_issue_stage_if #(
    parameter int WIDTH = 64
);
    logic             FLUSH;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic [1:0]       ALUOP;
    logic [2:0]       FUNCT3;
    logic [6:0]       FUNCT7;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       OPERATION;
    logic             ILLEGAL;
    logic [15:0]      ISSUE_CNT;

    modport master (
        output FLUSH, IN_VALID, IN_A, IN_B, ALUOP, FUNCT3, FUNCT7, OUT_READY,
        input  IN_READY, OUT_VALID, A, B, OPERATION, ILLEGAL, ISSUE_CNT
    );

    modport slave (
        input  FLUSH, IN_VALID, IN_A, IN_B, ALUOP, FUNCT3, FUNCT7, OUT_READY,
        output IN_READY, OUT_VALID, A, B, OPERATION, ILLEGAL, ISSUE_CNT
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue buffer in front of the 64-bit ALU. Operations are decoded into the
//   4-bit ALU OPERATION code at push time, held in a DEPTH-entry circular
//   buffer, and the oldest entry is presented from registers to the ALU.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : alu_issue_stage_if.slave (upstream handshake, ALU-side
//             handshake/operands, ISSUE_CNT)
module alu_issue_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        logic             ill;
    } entry_t;

    entry_t             r_mem [DEPTH];
    entry_t             r_head;      // registered copy of the oldest entry
    logic               r_out_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [15:0]        r_issue_cnt;

    entry_t             w_in;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_rd_nxt;

    assign bus.IN_READY  = (r_count < CNT_W'(DEPTH));
    assign bus.OUT_VALID = r_out_valid;
    assign bus.A         = r_head.a;
    assign bus.B         = r_head.b;
    assign bus.OPERATION = r_head.op;
    assign bus.ILLEGAL   = r_head.ill;
    assign bus.ISSUE_CNT = r_issue_cnt;

    assign w_push   = bus.IN_VALID & bus.IN_READY;
    assign w_pop    = r_out_valid & bus.OUT_READY;
    assign w_rd_nxt = r_rd_ptr + 1'b1;

    // Control decode; undecodable combinations issue as ADD flagged illegal.
    always_comb begin
        w_in.a   = bus.IN_A;
        w_in.b   = bus.IN_B;
        w_in.op  = 4'b0010;
        w_in.ill = 1'b0;
        case (bus.ALUOP)
            2'b00: w_in.op = 4'b0010;
            2'b01: w_in.op = 4'b0110;
            2'b10: begin
                if (bus.FUNCT7 == 7'b0000000 && bus.FUNCT3 == 3'b000)
                    w_in.op = 4'b0010;
                else if (bus.FUNCT7 == 7'b0000000 && bus.FUNCT3 == 3'b111)
                    w_in.op = 4'b0000;
                else if (bus.FUNCT7 == 7'b0000000 && bus.FUNCT3 == 3'b110)
                    w_in.op = 4'b0001;
                else if (bus.FUNCT7 == 7'b0100000 && bus.FUNCT3 == 3'b000)
                    w_in.op = 4'b0110;
                else
                    w_in.ill = 1'b1;
            end
            default: begin
                case (bus.FUNCT3)
                    3'b000:  w_in.op = 4'b0111;
                    3'b001:  w_in.op = 4'b1100;
                    3'b010:  w_in.op = 4'b0101;
                    default: w_in.ill = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_head      <= '0;
            r_out_valid <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_issue_cnt <= '0;
        end else if (bus.FLUSH) begin
            // Head data registers keep their last value; only validity drops.
            r_out_valid <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
                if (r_issue_cnt != 16'hFFFF) r_issue_cnt <= r_issue_cnt + 16'd1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            // Head register tracks the entry that becomes oldest after this
            // edge: the next buffered one, or the incoming one when the
            // buffer would otherwise drain.
            if (w_pop) begin
                if (r_count > CNT_W'(1)) begin
                    r_head      <= r_mem[w_rd_nxt];
                    r_out_valid <= 1'b1;
                end else if (w_push) begin
                    r_head      <= w_in;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_push && r_count == '0) begin
                r_head      <= w_in;
                r_out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Directed bench for alu_issue_stage (WIDTH=64, DEPTH=2). Inputs are driven
//   1 time unit after each rising edge and outputs sampled at the same point.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(64)) bus ();

    alu_issue_stage #(.WIDTH(64), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] aluop, input logic [6:0] f7,
                          input logic [2:0] f3);
        bus.IN_A   = a;
        bus.IN_B   = b;
        bus.ALUOP  = aluop;
        bus.FUNCT7 = f7;
        bus.FUNCT3 = f3;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ov"},  64'(bus.OUT_VALID), 64'd0);
        chk({tag, "_a"},   bus.A, 64'd0);
        chk({tag, "_b"},   bus.B, 64'd0);
        chk({tag, "_op"},  64'(bus.OPERATION), 64'd0);
        chk({tag, "_ill"}, 64'(bus.ILLEGAL), 64'd0);
        chk({tag, "_cnt"}, 64'(bus.ISSUE_CNT), 64'd0);
    endtask

    // decode sweep vectors and their hand-computed codes
    int v_aluop [10] = '{0, 1, 2, 2, 2, 2, 3, 3, 3, 2};
    int v_f7    [10] = '{0, 0, 0, 0, 0, 32, 0, 0, 0, 1};
    int v_f3    [10] = '{0, 0, 0, 7, 6, 0, 0, 1, 2, 0};
    int v_op    [10] = '{2, 6, 2, 0, 1, 6, 7, 12, 5, 2};
    int v_ill   [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        bus.FLUSH = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0;
        set_op(64'd0, 64'd0, 2'b00, 7'd0, 3'd0);
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        chk("rst_inrdy", 64'(bus.IN_READY), 64'd1);

        // 1: single push, one-edge latency, then pop
        set_op(64'd5, 64'd3, 2'b10, 7'b0100000, 3'b000);
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        chk("t1_ov",  64'(bus.OUT_VALID), 64'd1);
        chk("t1_a",   bus.A, 64'd5);
        chk("t1_b",   bus.B, 64'd3);
        chk("t1_op",  64'(bus.OPERATION), 64'h6);
        chk("t1_ill", 64'(bus.ILLEGAL), 64'd0);
        tick();
        exp_cnt++;
        chk("t1_ov2", 64'(bus.OUT_VALID), 64'd0);
        chk("t1_cnt", 64'(bus.ISSUE_CNT), 64'(exp_cnt));

        // 2: decode sweep
        for (int i = 0; i < 10; i++) begin
            set_op(64'(i + 100), 64'd7, 2'(v_aluop[i]), 7'(v_f7[i]), 3'(v_f3[i]));
            bus.IN_VALID = 1'b1;
            tick();
            bus.IN_VALID = 1'b0;
            chk($sformatf("t2_op%0d", i),  64'(bus.OPERATION), 64'(v_op[i]));
            chk($sformatf("t2_ill%0d", i), 64'(bus.ILLEGAL), 64'(v_ill[i]));
            tick();
            exp_cnt++;
        end
        chk("t2_cnt", 64'(bus.ISSUE_CNT), 64'(exp_cnt));

        // 3: backpressure, X/Y fill the buffer, Z waits upstream
        bus.OUT_READY = 1'b0;
        set_op(64'd10, 64'd1, 2'b00, 7'd0, 3'd0);
        bus.IN_VALID = 1'b1;
        tick();
        chk("t3_rdy1", 64'(bus.IN_READY), 64'd1);
        chk("t3_hx1",  bus.A, 64'd10);
        set_op(64'd20, 64'd2, 2'b01, 7'd0, 3'd0);
        tick();
        chk("t3_rdy2", 64'(bus.IN_READY), 64'd0);
        chk("t3_hx2",  bus.A, 64'd10);
        set_op(64'd30, 64'd3, 2'b11, 7'd0, 3'b000);
        tick();
        chk("t3_rdy3", 64'(bus.IN_READY), 64'd0);
        chk("t3_hx3a", bus.A, 64'd10);
        chk("t3_hx3o", 64'(bus.OPERATION), 64'h2);
        bus.OUT_READY = 1'b1;
        tick();
        exp_cnt++;
        chk("t3_ya",  bus.A, 64'd20);
        chk("t3_yo",  64'(bus.OPERATION), 64'h6);
        tick();
        exp_cnt++;
        bus.IN_VALID = 1'b0;
        chk("t3_za",  bus.A, 64'd30);
        chk("t3_zo",  64'(bus.OPERATION), 64'h7);
        tick();
        exp_cnt++;
        chk("t3_end", 64'(bus.OUT_VALID), 64'd0);
        chk("t3_cnt", 64'(bus.ISSUE_CNT), 64'(exp_cnt));

        // 4: steady stream, one in and one out per cycle
        set_op(64'd0, 64'd0, 2'b00, 7'd0, 3'd0);
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b1;
        bus.IN_A = 64'd1000;
        tick();
        for (int k = 1; k <= 100; k++) begin
            bus.IN_A = 64'(1000 + k);
            tick();
            exp_cnt++;
            chk($sformatf("t4_a%0d", k),  bus.A, 64'(1000 + k));
            chk($sformatf("t4_ov%0d", k), 64'(bus.OUT_VALID & bus.IN_READY), 64'd1);
        end
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0;
        tick();
        chk("t4_cnt", 64'(bus.ISSUE_CNT), 64'(exp_cnt));

        // 5: flush with two buffered plus an offered push
        set_op(64'd55, 64'd0, 2'b00, 7'd0, 3'd0);
        bus.IN_VALID = 1'b1;
        tick();
        chk("t5_full", 64'(bus.IN_READY), 64'd0);
        bus.FLUSH = 1'b1;
        bus.OUT_READY = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        bus.IN_VALID = 1'b0;
        chk("t5_ov",  64'(bus.OUT_VALID), 64'd0);
        chk("t5_rdy", 64'(bus.IN_READY), 64'd1);
        chk("t5_cnt", 64'(bus.ISSUE_CNT), 64'(exp_cnt));
        // flush with one buffered and an acceptable push: both discarded
        set_op(64'd66, 64'd0, 2'b00, 7'd0, 3'd0);
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b0;
        tick();
        set_op(64'd77, 64'd0, 2'b00, 7'd0, 3'd0);
        bus.FLUSH = 1'b1;
        bus.OUT_READY = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        bus.IN_VALID = 1'b0;
        tick();
        chk("t5_disc", 64'(bus.OUT_VALID), 64'd0);
        chk("t5_cnt2", 64'(bus.ISSUE_CNT), 64'(exp_cnt));

        // async reset mid-stream, checked before any further edge
        set_op(64'd88, 64'd9, 2'b01, 7'd0, 3'd0);
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b0;
        tick();
        chk("t5_pre", bus.A, 64'd88);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("t5_arst");
        bus.IN_VALID = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_rdy2", 64'(bus.IN_READY), 64'd1);
        exp_cnt = 0;

        // 6: saturation of ISSUE_CNT
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b1;
        bus.IN_A = 64'd0;
        tick();
        for (int k = 1; k <= 65540; k++) begin
            bus.IN_A = 64'(k);
            tick();
            if (exp_cnt < 16'hFFFF) exp_cnt++;
            if (k == 65534) chk("t6_fffe", 64'(bus.ISSUE_CNT), 64'h0FFFE);
            if (k == 65535) chk("t6_ffff", 64'(bus.ISSUE_CNT), 64'h0FFFF);
        end
        bus.IN_VALID = 1'b0;
        chk("t6_hold", 64'(bus.ISSUE_CNT), 64'(exp_cnt));
        chk("t6_a",    bus.A, 64'd65540);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Issue stage directly upstream of the 64-bit ALU. It accepts operand pairs plus control fields over a valid/ready handshake and decodes the control fields into the ALU's 4-bit OPERATION code. It buffers up to DEPTH issued operations and presents the oldest one, registered, to the ALU inputs A, B and OPERATION. Downstream backpressure therefore never drops or corrupts an operation.

Parameters:
WIDTH, 64, operand width; matches the ALU data path.
DEPTH, 2, buffer entries; must be a power of two, at least 2.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
FLUSH  input  1  synchronous flush; discards all buffered entries.
IN_VALID  input  1  upstream has an operation.
IN_READY  output  1  stage can accept this cycle.
IN_A  input  WIDTH  operand A.
IN_B  input  WIDTH  operand B (register or immediate, already selected).
ALUOP  input  2  main-decoder ALU class.
FUNCT3  input  3  instruction funct3.
FUNCT7  input  7  instruction funct7.
OUT_VALID  output  1  head entry valid.
OUT_READY  input  1  ALU/EX consumer accepts the head.
A  output  WIDTH  head operand A, to ALU A.
B  output  WIDTH  head operand B, to ALU B.
OPERATION  output  4  head decoded op, to ALU OPERATION.
ILLEGAL  output  1  head entry carried an undecodable control combination.
ISSUE_CNT  output  16  count of operations popped since reset; saturating.

Behaviour:
- Push: IN_VALID and IN_READY on a rising edge. Pop: OUT_VALID and OUT_READY on a rising edge.
- IN_READY = (count < DEPTH). It is derived from registered state only, with no combinational path from OUT_READY.
- A, B, OPERATION, ILLEGAL and OUT_VALID come straight from the head-entry registers.
- Latency: with the buffer empty, a push at edge N gives OUT_VALID=1 with that entry's data after edge N. No bypass path.
- Decode, performed at push and stored per entry:
  - ALUOP=00: 0010 (ADD).
  - ALUOP=01: 0110 (SUB).
  - ALUOP=10, R-type:
    - FUNCT7=0000000: FUNCT3=000 gives 0010 ADD; 111 gives 0000 AND; 110 gives 0001 OR.
    - FUNCT7=0100000 with FUNCT3=000 gives 0110 SUB.
  - ALUOP=11: FUNCT3=000 gives 0111 (pass B); 001 gives 1100 (NOR); 010 gives 0101 (-A-B).
  - Any other combination: OPERATION=0010 and ILLEGAL=1 for that entry. The entry is still issued.
- Buffer: circular, with wrapping read/write pointers and an occupancy count from 0 to DEPTH. Entries leave in FIFO order.
- Simultaneous push and pop:
  - count=0: push only (OUT_VALID=0, so no pop).
  - 0<count<DEPTH: count is unchanged and the head advances.
  - count=DEPTH: IN_READY=0, so it is pop only.
- OUT_READY=0 with OUT_VALID=1: A, B, OPERATION and ILLEGAL hold stable until popped.
- ISSUE_CNT increments on every pop and saturates at 16'hFFFF.
- FLUSH: on the next edge count=0, pointers=0 and OUT_VALID=0. A push or pop in the same cycle is ignored. ISSUE_CNT is unaffected.
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - count, pointers and ISSUE_CNT are 0.
  - OUT_VALID=0, A=0, B=0, OPERATION=4'b0000, ILLEGAL=0.
  - IN_READY=1 after reset deasserts.
- While OUT_VALID=0, A, B, OPERATION and ILLEGAL hold their last values (0 after reset). The consumer must ignore them.

Test Plan:
1. Reset then single push: IN_A=5, IN_B=3, ALUOP=10, FUNCT7=0100000, FUNCT3=000, OUT_READY=1 -> one edge later OUT_VALID=1, A=5, B=3, OPERATION=0110, ILLEGAL=0. It pops the next edge and ISSUE_CNT=1.
2. Decode sweep, one push per legal combination -> OPERATION sequence 0010, 0110, 0010, 0000, 0001, 0110, 0111, 1100, 0101 in order. ALUOP=10, FUNCT7=0000001, FUNCT3=000 -> OPERATION=0010, ILLEGAL=1.
3. Backpressure: OUT_READY=0, push ops X, Y, Z -> IN_READY=0 after 2 pushes (DEPTH=2), Z is held upstream, and head X stays stable. Release OUT_READY -> outputs X, Y, Z in order with no loss.
4. Steady stream with count=1: push and pop every cycle for 100 cycles -> count stays 1, one op issued per cycle, ISSUE_CNT=100, pointer wrap is correct.
5. Two entries buffered, FLUSH=1 with IN_VALID=1 -> next edge OUT_VALID=0, IN_READY=1, and the pushed op is discarded. Async rst_n pulse mid-stream -> all outputs at reset values immediately, without a clock edge.
6. ISSUE_CNT preset near saturation via 65540 pops -> reads 16'hFFFF and holds.
